// File: rtl/aha_uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter slice.
// Used by aha_uart_tx_arbiter, its interface and the round-robin picker.
package aha_uart_arb_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    // Ceiling log2; callers clamp to a minimum width of 1 where needed.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/aha_uart_tx_arbiter_if.sv
// Handshake bundle between requester byte FIFOs, the arbiter and the UART TX shifter.
// The slave modport is the arbiter's view; master is the surrounding SoC (or a bench).
interface aha_uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    import aha_uart_arb_pkg::*;

    logic [NUM_REQ-1:0]        REQ_VALID;
    logic [NUM_REQ*BYTE_W-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]        REQ_LAST;
    logic [NUM_REQ-1:0]        REQ_READY;
    logic                      TX_VALID;
    logic [BYTE_W-1:0]         TX_DATA;
    logic                      TX_READY;
    logic [NUM_REQ-1:0]        GRANT;
    logic                      BUSY;

    modport master (
        output REQ_VALID, REQ_DATA, REQ_LAST, TX_READY,
        input  REQ_READY, TX_VALID, TX_DATA, GRANT, BUSY
    );

    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_LAST, TX_READY,
        output REQ_READY, TX_VALID, TX_DATA, GRANT, BUSY
    );

endinterface

// File: rtl/aha_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// Returns the one-hot winner, its index, and whether any request was present.
module aha_rr_picker #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Two passes: indices at/after ptr first, then the wrapped-around low indices.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!any && req[j] && (j >= 32'(ptr))) begin
                onehot[j] = 1'b1;
                idx       = IDX_W'(j);
                any       = 1'b1;
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (!any && req[j]) begin
                onehot[j] = 1'b1;
                idx       = IDX_W'(j);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aha_uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX channel among NUM_REQ byte streams.
// Define AHA_UART_ARB_TAG_EN to prefix each grant with a source tag byte (TAG_BASE + index).
module aha_uart_tx_arbiter
    import aha_uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MAX_BURST = 64,
    parameter logic [7:0]  TAG_BASE  = 8'h30
) (
    input logic                  CLK,
    input logic                  RESET,
    aha_uart_tx_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = clog2(NUM_REQ);
    localparam int unsigned CNT_W = (MAX_BURST > 1) ? clog2(MAX_BURST) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("aha_uart_tx_arbiter: NUM_REQ must be 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_max_burst
        $error("aha_uart_tx_arbiter: MAX_BURST must be 1..256");
    end
    if (int'(TAG_BASE) + int'(NUM_REQ) > 256) begin : g_bad_tag_base
        $error("aha_uart_tx_arbiter: TAG_BASE + NUM_REQ overflows a byte");
    end

    arb_state_t         state, state_n;
    logic [NUM_REQ-1:0] grant, grant_n;
    logic [IDX_W-1:0]   gidx, gidx_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic               valid_g, last_g;
    logic [BYTE_W-1:0]  data_g;

    logic               tx_valid;
    logic [BYTE_W-1:0]  tx_data;
    logic [NUM_REQ-1:0] req_ready;

    aha_rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (bus.REQ_VALID),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // One-hot mux of the granted requester's byte lane.
    always_comb begin
        valid_g = |(bus.REQ_VALID & grant);
        last_g  = |(bus.REQ_LAST & grant);
        data_g  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) data_g = bus.REQ_DATA[i*BYTE_W +: BYTE_W];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            grant <= '0;
            gidx  <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            gidx  <= gidx_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        gidx_n    = gidx;
        ptr_n     = ptr;
        cnt_n     = cnt;
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_n = pick_onehot;
                    gidx_n  = pick_idx;
`ifdef AHA_UART_ARB_TAG_EN
                    state_n = TAG;
`else
                    state_n = XFER;
`endif
                end
            end
`ifdef AHA_UART_ARB_TAG_EN
            TAG: begin
                tx_valid = 1'b1;
                tx_data  = TAG_BASE + BYTE_W'(gidx);
                if (bus.TX_READY) state_n = XFER;
            end
`endif
            XFER: begin
                tx_valid  = valid_g;
                tx_data   = data_g;
                req_ready = grant & {NUM_REQ{bus.TX_READY}};
                if (valid_g && bus.TX_READY) begin
                    if (last_g || cnt == CNT_W'(MAX_BURST - 1)) begin
                        state_n = IDLE;
                        grant_n = '0;
                        cnt_n   = '0;
                        ptr_n   = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.TX_VALID  = tx_valid;
    assign bus.TX_DATA   = tx_data;
    assign bus.REQ_READY = req_ready;
    assign bus.GRANT     = grant;
    assign bus.BUSY      = (state != IDLE);

endmodule

// File: doc/aha_uart_tx_arbiter.md
Name: aha_uart_tx_arbiter

Overview:
- Shares one UART transmit channel (UART0_TXD path of AhaGarnetSoC) between NUM_REQ byte-stream requesters, e.g. the CPU console and the debug/trace reporter.
- Uses round-robin arbitration at packet granularity. A grant is held until the requester's last byte or until the burst limit, so lines from different sources never interleave in the capture log.
- Sits between the requester byte FIFOs and the UART TX shift register. Both sides use valid/ready handshakes.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- MAX_BURST, 64: maximum bytes per grant, 1..256; forces re-arbitration.
- TAG_BASE, 8'h30: base character for the optional source tag (ASCII '0').

Ports:
- CLK, input, 1: single clock.
- RESET, input, 1: asynchronous, active-high reset.
- REQ_VALID, input, NUM_REQ: per-requester byte valid.
- REQ_DATA, input, NUM_REQ*8: per-requester byte; requester i occupies bits [8i+7:8i].
- REQ_LAST, input, NUM_REQ: byte is end of packet (e.g. '\n').
- REQ_READY, output, NUM_REQ: byte accepted when VALID&READY.
- TX_VALID, output, 1: byte to UART TX valid.
- TX_DATA, output, 8: byte to UART TX.
- TX_READY, input, 1: UART TX can accept a byte.
- GRANT, output, NUM_REQ: one-hot current owner; 0 when idle.
- BUSY, output, 1: arbiter is in a non-IDLE state.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - GRANT=0, BUSY=0, TX_VALID=0, TX_DATA=0, REQ_READY=0.
  - RR pointer=0, so requester 0 has top priority first.
  - Beat counter=0.
- States: IDLE, TAG (only with the optional feature), XFER.
- IDLE:
  - Picks the first asserted REQ_VALID searching from pointer, pointer+1, ... with wrap modulo NUM_REQ.
  - Registers the one-hot GRANT and moves to XFER (or TAG) on the next edge.
  - No REQ_VALID: stays in IDLE.
  - Arbitration latency is 1 cycle: TX_VALID can rise the cycle after REQ_VALID first rises in IDLE.
- XFER:
  - TX_VALID = REQ_VALID[g]; TX_DATA = REQ_DATA[g]; REQ_READY[g] = TX_READY. These are combinational passthroughs, so there is no bubble between bytes.
  - REQ_READY of non-granted requesters is 0.
  - Beat counter increments on each TX_VALID&TX_READY.
- Packet end: an accepted beat with REQ_LAST[g]=1, or counter==MAX_BURST-1, sends the state to IDLE.
  - GRANT clears, pointer = g+1 (wrap), counter clears.
  - At least one IDLE cycle always separates grants, and that cycle re-arbitrates.
- Grant holding:
  - A granted requester that drops REQ_VALID mid-packet keeps the grant; TX_VALID=0 meanwhile.
  - There is no timeout.
- Simultaneous REQ_VALID from all requesters: grants cycle strictly in pointer order, so each requester waits at most NUM_REQ-1 packets.
- Reset asserted mid-packet: immediate return to reset values; the partial packet is abandoned.
- Input stability: TX_DATA must be stable while TX_VALID=1 and TX_READY=0. This is guaranteed by the requester valid/ready contract.
- Burst limit: with MAX_BURST=1, every byte is a separate grant.

Optional Feature:
- Macro AHA_UART_ARB_TAG_EN.
- Defined:
  - IDLE goes to TAG after a grant.
  - TAG drives TX_VALID=1 and TX_DATA=TAG_BASE+g, with REQ_READY=0.
  - On TX_READY it moves to XFER.
  - The tag does not count toward MAX_BURST.
  - Latency to the first payload byte is 2 cycles.
- Undefined:
  - The TAG state and its logic are absent.
  - IDLE goes directly to XFER.

Decomposition:
- Package aha_uart_arb_pkg:
  - State enum (IDLE, TAG, XFER).
  - Byte width constant 8.
  - Counter width function clog2(MAX_BURST).
- Sub-module aha_rr_picker:
  - Combinational.
  - Inputs: request vector and pointer. Output: one-hot winner and its index.
  - Reusable by other SoC arbiters.

Test Plan:
1. Reset and idle: RESET=1 for 3 cycles, no requests. GRANT=0, TX_VALID=0 and BUSY=0 throughout; one cycle after release, still all 0.
2. Single packet: req0 sends "OK\n" (8'h4F,8'h4B,8'h0A LAST), TX_READY=1. GRANT=01 one cycle after REQ_VALID; 3 bytes in 3 consecutive cycles; GRANT=0 next cycle.
3. Contention: req0 and req1 each send 2-byte packets continuously. Order is req0, req1, req0, req1, and no bytes interleave within a packet.
4. Backpressure and stall: TX_READY toggles 1,0,1,0; req1 drops VALID for 2 cycles mid-packet. Grant holds, bytes arrive in order, and REQ_READY[0]=0 throughout.
5. Burst limit with MAX_BURST=4: req0 sends 10 bytes without LAST while req1 waits. Order is req0×4, req1 packet, req0×4, and so on.
6. Reset and tag: RESET pulsed during byte 2 gives immediate GRANT=0, and the next arbitration starts from req0. With AHA_UART_ARB_TAG_EN, req1 "A" gives output 8'h31, 8'h41.
